// File: rtl/input_buffer_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_buffer_ctrl_pkg                                                |
// | Shared constants, state encoding and config types for the input      |
// | buffer read sequencer.                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package input_buffer_ctrl_pkg;

    localparam int sys_rows           = 4;
    localparam int input_buffer_depth = 64;

    localparam int LEN_W_DEF       = 16;
    localparam int TILE_W_DEF      = 8;
    localparam int EXTRA_DRAIN_DEF = 2;
    localparam int INBUF_DRAIN_CYC = sys_rows - 1 + EXTRA_DRAIN_DEF;

    typedef logic [LEN_W_DEF-1:0]  cfg_len_t;
    typedef logic [TILE_W_DEF-1:0] cfg_tiles_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } inbuf_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/input_buffer_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter                                                          |
// | Event counter with synchronous clear that sticks at all-ones.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/input_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_buffer_ctrl                                                    |
// | Issues per-tile read bursts to the skewed input buffer, draining the |
// | row-skew pipeline between tiles. INBUF_CTRL_PERF_EN adds counters.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module input_buffer_ctrl
    import input_buffer_ctrl_pkg::*;
#(
    parameter int LEN_W       = 16,
    parameter int TILE_W      = 8,
    parameter int EXTRA_DRAIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic              stall,
    output logic              read,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [TILE_W-1:0] tile_idx,
    output logic [LEN_W-1:0]  vec_idx,
    output logic              tile_first,
    output logic              tile_last
`ifdef INBUF_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_read_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int c_DRAIN_CYC = sys_rows - 1 + EXTRA_DRAIN;
    localparam int c_DC_W      = (c_DRAIN_CYC < 2) ? 1 : $clog2(c_DRAIN_CYC + 1);

    inbuf_ctrl_state_t r_state;
    inbuf_ctrl_state_t w_state_nxt;

    logic [LEN_W-1:0]  r_len_q;
    logic [TILE_W-1:0] r_tiles_q;
    logic [TILE_W-1:0] r_tile_idx;
    logic [LEN_W-1:0]  r_vec_idx;
    logic [c_DC_W-1:0] r_drain_cnt;
    logic              r_done;
    logic              r_err;

    logic w_cfg_ok;
    logic w_accept;
    logic w_read;
    logic w_last_vec;
    logic w_last_tile;
    logic w_drain_end;

    assign w_cfg_ok    = (cfg_len != '0) && (cfg_tiles != '0) &&
                         (32'(cfg_len) <= 32'(input_buffer_depth));
    assign w_accept    = start && (r_state == IDLE) && w_cfg_ok;
    assign w_read      = (r_state == LOAD) && !stall && !rst;
    assign w_last_vec  = (r_vec_idx == (r_len_q - LEN_W'(1)));
    assign w_last_tile = (r_tile_idx == (r_tiles_q - TILE_W'(1)));
    assign w_drain_end = (r_drain_cnt == c_DC_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = LOAD;
            end
            LOAD: begin
                if (w_read && w_last_vec) begin
                    // A zero-length drain takes the tile decision straight from the last read.
                    if (c_DRAIN_CYC == 0) begin
                        w_state_nxt = w_last_tile ? DONE : LOAD;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_drain_end) w_state_nxt = w_last_tile ? DONE : LOAD;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_q     <= '0;
            r_tiles_q   <= '0;
            r_tile_idx  <= '0;
            r_vec_idx   <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            r_err  <= start && !w_accept;
            if (w_accept) begin
                r_len_q    <= cfg_len;
                r_tiles_q  <= cfg_tiles;
                r_tile_idx <= '0;
                r_vec_idx  <= '0;
            end
            case (r_state)
                LOAD: begin
                    if (w_read) begin
                        if (w_last_vec) begin
                            r_vec_idx   <= '0;
                            r_drain_cnt <= c_DC_W'(c_DRAIN_CYC);
                            if ((c_DRAIN_CYC == 0) && !w_last_tile) begin
                                r_tile_idx <= r_tile_idx + TILE_W'(1);
                            end
                        end else begin
                            r_vec_idx <= r_vec_idx + LEN_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    r_drain_cnt <= r_drain_cnt - c_DC_W'(1);
                    if (w_drain_end && !w_last_tile) begin
                        r_tile_idx <= r_tile_idx + TILE_W'(1);
                    end
                end
                DONE: begin
                    r_tile_idx <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status is masked during reset so the reset cycle itself reads as idle.
    assign read       = w_read;
    assign busy       = (r_state != IDLE) && !rst;
    assign done       = r_done && !rst;
    assign err        = r_err && !rst;
    assign tile_idx   = rst ? '0 : r_tile_idx;
    assign vec_idx    = rst ? '0 : r_vec_idx;
    assign tile_first = w_read && (r_vec_idx == '0);
    assign tile_last  = w_read && w_last_vec;

`ifdef INBUF_CTRL_PERF_EN
    sat_counter #(.WIDTH(32)) u_perf_read (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_accept),
        .inc   (w_read),
        .count (perf_read_cnt)
    );

    sat_counter #(.WIDTH(32)) u_perf_stall (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_accept),
        .inc   ((r_state == LOAD) && stall),
        .count (perf_stall_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_input_buffer_ctrl                                                 |
// | Scoreboard bench: two DUTs (EXTRA_DRAIN 0 and 2) on shared stimulus. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_input_buffer_ctrl;
    import input_buffer_ctrl_pkg::*;

    localparam int LEN_W  = 16;
    localparam int TILE_W = 8;
    localparam int D0     = sys_rows - 1;
    localparam int D1     = sys_rows - 1 + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [TILE_W-1:0] cfg_tiles = '0;

    logic              rd [2];
    logic              bz [2];
    logic              dn [2];
    logic              er [2];
    logic              tf [2];
    logic              tl [2];
    logic [TILE_W-1:0] ti [2];
    logic [LEN_W-1:0]  vi [2];
`ifdef INBUF_CTRL_PERF_EN
    logic [31:0]       prc [2];
    logic [31:0]       psc [2];
`endif

    input_buffer_ctrl #(.LEN_W(LEN_W), .TILE_W(TILE_W), .EXTRA_DRAIN(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_tiles(cfg_tiles),
        .stall(stall), .read(rd[0]), .busy(bz[0]), .done(dn[0]), .err(er[0]),
        .tile_idx(ti[0]), .vec_idx(vi[0]), .tile_first(tf[0]), .tile_last(tl[0])
`ifdef INBUF_CTRL_PERF_EN
        , .perf_read_cnt(prc[0]), .perf_stall_cnt(psc[0])
`endif
    );

    input_buffer_ctrl #(.LEN_W(LEN_W), .TILE_W(TILE_W), .EXTRA_DRAIN(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_tiles(cfg_tiles),
        .stall(stall), .read(rd[1]), .busy(bz[1]), .done(dn[1]), .err(er[1]),
        .tile_idx(ti[1]), .vec_idx(vi[1]), .tile_first(tf[1]), .tile_last(tl[1])
`ifdef INBUF_CTRL_PERF_EN
        , .perf_read_cnt(prc[1]), .perf_stall_cnt(psc[1])
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = read, 1 = done, 2 = err
    typedef struct {
        int w;
        int kind;
        int cyc;
        int tile;
        int vec;
        bit first;
        bit last;
    } ev_t;

    ev_t exp_q[$];
    int  blo [2] = '{1, 1};
    int  bhi [2] = '{0, 0};
    int  done_at [2];
    int  exp_prc [2];
    int  exp_psc [2];
    bit  st [1024];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string name, input int w, input longint act, input longint expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, w, cyc, act, expv);
        end
    endtask

    task automatic take(input int w, input int kind, input int tile, input int vec,
                        input bit f, input bit l);
        int idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i].w == w && exp_q[i].kind == kind) idx = i;
        if (idx < 0) begin
            chk(kind == 0 ? "spurious_read" : (kind == 1 ? "spurious_done" : "spurious_err"), w, 1, 0);
            return;
        end
        chk(kind == 0 ? "read_cycle" : (kind == 1 ? "done_cycle" : "err_cycle"), w, cyc, exp_q[idx].cyc);
        if (kind == 0) begin
            chk("tile_idx", w, tile, exp_q[idx].tile);
            chk("vec_idx", w, vec, exp_q[idx].vec);
            chk("tile_first", w, f, exp_q[idx].first);
            chk("tile_last", w, l, exp_q[idx].last);
        end
        exp_q.delete(idx);
    endtask

    // Monitor: pops an expectation whenever a DUT presents read/done/err.
    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            chk("busy", w, bz[w], (cyc >= blo[w] && cyc <= bhi[w]) ? 1 : 0);
            if (rd[w]) take(w, 0, int'(ti[w]), int'(vi[w]), tf[w], tl[w]);
            if (dn[w]) take(w, 1, 0, 0, 1'b0, 1'b0);
            if (er[w]) take(w, 2, 0, 0, 1'b0, 1'b0);
        end
    end

    // Reference: walk the command as tiles of len reads, skipping stalled cycles, then d idle cycles.
    task automatic plan(input int w, input int s, input int len, input int tiles, input int d);
        int c  = s + 1;
        int ns = 0;
        for (int t = 0; t < tiles; t++) begin
            for (int v = 0; v < len; v++) begin
                while (st[c - s]) begin
                    c++;
                    ns++;
                end
                exp_q.push_back('{w, 0, c, t, v, (v == 0), (v == len - 1)});
                c++;
            end
            c += d;
        end
        exp_q.push_back('{w, 1, c + 1, 0, 0, 1'b0, 1'b0});
        blo[w]     = s + 1;
        bhi[w]     = c;
        done_at[w] = c + 1;
        exp_prc[w] = len * tiles;
        exp_psc[w] = ns;
    endtask

    task automatic fill_st(input int pct);
        foreach (st[i]) st[i] = (pct > 0) && ($urandom_range(99) < pct);
    endtask

    task automatic check_drained();
        chk("leftover_events", 0, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_cmd(input int len, input int tiles, input bit mid_start);
        int s;
        int fin;
        @(posedge clk); #1;
        s         = cyc;
        start     = 1'b1;
        cfg_len   = LEN_W'(len);
        cfg_tiles = TILE_W'(tiles);
        plan(0, s, len, tiles, D0);
        plan(1, s, len, tiles, D1);
        fin = (done_at[0] > done_at[1]) ? done_at[0] : done_at[1];
        @(posedge clk); #1;
        while (cyc <= fin + 1) begin
            stall = (cyc - s < 1024) ? st[cyc - s] : 1'b0;
            if (mid_start && cyc == s + 2) begin
                start     = 1'b1;
                cfg_len   = LEN_W'($urandom_range(1, 8));
                cfg_tiles = TILE_W'($urandom_range(1, 4));
                exp_q.push_back('{0, 2, s + 3, 0, 0, 1'b0, 1'b0});
                exp_q.push_back('{1, 2, s + 3, 0, 0, 1'b0, 1'b0});
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        check_drained();
`ifdef INBUF_CTRL_PERF_EN
        for (int w = 0; w < 2; w++) begin
            chk("perf_read_cnt", w, prc[w], exp_prc[w]);
            chk("perf_stall_cnt", w, psc[w], exp_psc[w]);
        end
`endif
    endtask

    task automatic bad_start(input int len, input int tiles);
        int s;
        @(posedge clk); #1;
        s         = cyc;
        start     = 1'b1;
        cfg_len   = LEN_W'(len);
        cfg_tiles = TILE_W'(tiles);
        exp_q.push_back('{0, 2, s + 1, 0, 0, 1'b0, 1'b0});
        exp_q.push_back('{1, 2, s + 1, 0, 0, 1'b0, 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_drained();
    endtask

    task automatic reset_in_drain();
        int s;
        fill_st(0);
        @(posedge clk); #1;
        s         = cyc;
        start     = 1'b1;
        cfg_len   = LEN_W'(3);
        cfg_tiles = TILE_W'(4);
        plan(0, s, 3, 4, D0);
        plan(1, s, 3, 4, D1);
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < s + 5) begin
            @(posedge clk); #1;
        end
        // Both DUTs sit in tile-0 drain here; everything still pending is abandoned.
        exp_q.delete();
        bhi[0] = s + 4;
        bhi[1] = s + 4;
        rst    = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk("rst_tile_idx", w, ti[w], 0);
            chk("rst_vec_idx", w, vi[w], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk("post_rst_tile_idx", w, ti[w], 0);
            chk("post_rst_vec_idx", w, vi[w], 0);
        end
        repeat (6) @(posedge clk);
        #1;
        check_drained();
    endtask

    initial begin
        int r;
        int len;
        int tiles;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk("reset_tile_idx", w, ti[w], 0);
            chk("reset_vec_idx", w, vi[w], 0);
            chk("reset_done", w, dn[w], 0);
            chk("reset_err", w, er[w], 0);
        end

        fill_st(0);
        run_cmd(5, 2, 1'b0);
        fill_st(0);
        st[3] = 1'b1;
        st[4] = 1'b1;
        run_cmd(5, 2, 1'b0);
        bad_start(0, 1);
        bad_start(input_buffer_depth + 1, 1);
        bad_start(3, 0);
        fill_st(0);
        run_cmd(4, 2, 1'b1);
        reset_in_drain();
        fill_st(0);
        run_cmd(3, 4, 1'b0);
        fill_st(0);
        run_cmd(1, 3, 1'b0);
        fill_st(0);
        run_cmd(input_buffer_depth, 1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(9);
            if (r == 0) begin
                case ($urandom_range(2))
                    0:       bad_start(0, $urandom_range(1, 5));
                    1:       bad_start($urandom_range(input_buffer_depth + 1, 200), $urandom_range(1, 5));
                    default: bad_start($urandom_range(1, 8), 0);
                endcase
            end else begin
                len   = $urandom_range(1, 6);
                tiles = $urandom_range(1, 3);
                fill_st(20);
                run_cmd(len, tiles, (r == 1));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
